wreg_chain: RTL and testbench

- Parametrised successor to the single-stage horizontal buffer.
- DEPTH-stage chain of WIDTH-bit registers, each with a valid bit. Shared enable and clear.
- Runtime-selectable output tap and a count of valid stages.
- Used as the horizontal skew/delay line feeding systolic PE rows. Row r sets tap r, so one RTL block provides every skew depth.

---
 rtl/wreg_chain.sv | 131 +++++++++++++
 tb/tb_wreg_chain.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wreg_chain.sv
// -----------------------------------------------------------------------------
// wreg_chain
//   DEPTH-stage chain of WIDTH-bit registers, each stage carrying a valid bit.
//   Shared enable (advance) and synchronous clear. A runtime tap select picks
//   which stage drives the outputs, so one block serves as the skew/delay line
//   for every row of a systolic PE array (row r selects tap r).
//
//   Optional build macro: WREG_CHAIN_ZERO_GATE_EN
//     defined   : invalid samples enter stage 0 as zero, so o_data is 0
//                 whenever o_valid is 0 (cuts downstream multiplier toggling).
//     undefined : stage 0 captures i_data unconditionally.
//
// Ports
//   clk      in   clock, all state updates on posedge
//   rst_n    in   synchronous active-low reset
//   en       in   advance the chain by one stage
//   clr      in   synchronous flush of all stages (beats en)
//   i_valid  in   valid qualifier for i_data
//   i_data   in   WIDTH-bit data into stage 0
//   i_tap    in   stage index driven to the outputs (clamped to DEPTH-1)
//   o_valid  out  valid bit of the selected stage
//   o_data   out  data of the selected stage
//   o_cnt    out  number of stages holding valid=1
//   o_full   out  all DEPTH stages valid
//   o_empty  out  no stage valid
// -----------------------------------------------------------------------------
module wreg_chain #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int TAPW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [TAPW-1:0]  i_tap,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNTW-1:0]  o_cnt,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] stg_q [DEPTH];
  logic [WIDTH-1:0] stg_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] din;
  logic [TAPW-1:0]  tap_sel;

`ifdef WREG_CHAIN_ZERO_GATE_EN
  assign din = i_valid ? i_data : '0;
`else
  assign din = i_data;
`endif

  // Next-state: clr beats en; en shifts every stage one step toward the end.
  always_comb begin
    stg_d = stg_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        stg_d[k] = '0;
      end
      vld_d = '0;
      cnt_d = '0;
    end else if (en) begin
      stg_d[0] = din;
      vld_d[0] = i_valid;
      for (int k = 1; k < DEPTH; k++) begin
        stg_d[k] = stg_q[k-1];
        vld_d[k] = vld_q[k-1];
      end
      // Bounded to 0..DEPTH: a push into a full chain always drops a valid.
      cnt_d = cnt_q + CNTW'(i_valid) - CNTW'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stg_q[k] <= '0;
      end
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      stg_q <= stg_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  // Clamp only matters when the tap field can encode indices past DEPTH-1.
  generate
    if ((1 << TAPW) > DEPTH) begin : g_clamp
      localparam logic [TAPW-1:0] LAST_TAP = TAPW'(DEPTH - 1);
      assign tap_sel = (i_tap > LAST_TAP) ? LAST_TAP : i_tap;
    end else begin : g_direct
      assign tap_sel = i_tap;
    end
  endgenerate

  assign o_data  = stg_q[tap_sel];
  assign o_valid = vld_q[tap_sel];
  assign o_cnt   = cnt_q;
  assign o_full  = (cnt_q == CNTW'(DEPTH));
  assign o_empty = (cnt_q == '0);

`ifndef SYNTHESIS
  function automatic logic [CNTW-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [CNTW-1:0] p;
    p = '0;
    for (int k = 0; k < DEPTH; k++) begin
      p = p + CNTW'(v[k]);
    end
    return p;
  endfunction

  // The occupancy counter is a cheap shadow of popcount(vld).
  always @(posedge clk) begin
    if (rst_n) begin
      assert (cnt_q == popcnt(vld_q));
    end
  end
`endif

endmodule

// File: tb/tb_wreg_chain.sv
module tb_wreg_chain;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, i_valid;
  logic [15:0] i_data;
  logic [1:0]  i_tap;

  logic        o_valid, o_full, o_empty;
  logic [15:0] o_data;
  logic [2:0]  o_cnt;

  // second instance (DEPTH=3) exercises the out-of-range tap clamp
  logic        o3_valid, o3_full, o3_empty;
  logic [15:0] o3_data;
  logic [1:0]  o3_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wreg_chain #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .i_valid(i_valid),
    .i_data(i_data), .i_tap(i_tap), .o_valid(o_valid), .o_data(o_data),
    .o_cnt(o_cnt), .o_full(o_full), .o_empty(o_empty));

  wreg_chain #(.WIDTH(16), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .i_valid(i_valid),
    .i_data(i_data), .i_tap(i_tap), .o_valid(o3_valid), .o_data(o3_data),
    .o_cnt(o3_cnt), .o_full(o3_full), .o_empty(o3_empty));

  typedef struct {
    logic        rst_n, en, clr, vi;
    logic [15:0] d;
    logic [1:0]  tap;
    logic        e_valid;
    logic [15:0] e_data;   // raw stage content (ungated build)
    logic [2:0]  e_cnt;
    logic        e_full, e_empty;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic c, input logic v,
                              input logic [15:0] d, input logic [1:0] t,
                              input logic ev, input logic [15:0] ed, input logic [2:0] ec,
                              input logic ef, input logic ee);
    vec_t x;
    x.rst_n = r; x.en = e; x.clr = c; x.vi = v; x.d = d; x.tap = t;
    x.e_valid = ev; x.e_data = ed; x.e_cnt = ec; x.e_full = ef; x.e_empty = ee;
    return x;
  endfunction

  // Drive one vector at negedge, queue its expectation, compare after the edge.
  task automatic step(input vec_t x, input string tag);
    vec_t e;
    logic [15:0] exp_d;
    rst_n = x.rst_n; en = x.en; clr = x.clr; i_valid = x.vi;
    i_data = x.d; i_tap = x.tap;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
`ifdef WREG_CHAIN_ZERO_GATE_EN
    exp_d = e.e_valid ? e.e_data : 16'h0;
`else
    exp_d = e.e_data;
`endif
    chk({tag, ".valid"}, {31'b0, o_valid}, {31'b0, e.e_valid});
    chk({tag, ".data"},  {16'b0, o_data},  {16'b0, exp_d});
    chk({tag, ".cnt"},   {29'b0, o_cnt},   {29'b0, e.e_cnt});
    chk({tag, ".full"},  {31'b0, o_full},  {31'b0, e.e_full});
    chk({tag, ".empty"}, {31'b0, o_empty}, {31'b0, e.e_empty});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; i_valid = 1'b0; i_data = '0; i_tap = '0;
    @(negedge clk);

    //            rst en clr vi  data      tap  ev  edata     cnt full empty
    // reset with busy inputs, then release with en=0
    vecs.push_back(mk(0, 1, 0, 1, 16'hFFFF, 2'd0, 0, 16'h0000, 3'd0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 16'hFFFF, 2'd3, 0, 16'h0000, 3'd0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 16'h1234, 2'd0, 0, 16'h0000, 3'd0, 0, 1));
    // fill, observed at tap 2: 0011 arrives on the third en edge
    vecs.push_back(mk(1, 1, 0, 1, 16'h0011, 2'd2, 0, 16'h0000, 3'd1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 16'h0022, 2'd2, 0, 16'h0000, 3'd2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 16'h0033, 2'd2, 1, 16'h0011, 3'd3, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 16'h0044, 2'd2, 1, 16'h0022, 3'd4, 1, 0));
    // stall: 5 cycles en=0, input ignored
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 0, 1, 16'hDEAD, 2'd2, 1, 16'h0022, 3'd4, 1, 0));
    // resume: no lost / duplicated sample; full stays at 4
    vecs.push_back(mk(1, 1, 0, 1, 16'h0055, 2'd2, 1, 16'h0033, 3'd4, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 16'h0066, 2'd3, 1, 16'h0033, 3'd4, 1, 0));
    // drain with invalid pushes
    vecs.push_back(mk(1, 1, 0, 0, 16'h0077, 2'd0, 0, 16'h0077, 3'd3, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0088, 2'd3, 1, 16'h0055, 3'd2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0099, 2'd3, 1, 16'h0066, 3'd1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h00AA, 2'd3, 0, 16'h0077, 3'd0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 16'h00BB, 2'd3, 0, 16'h0088, 3'd0, 0, 1));
    // refill two, then clr together with en and a valid ABCD
    vecs.push_back(mk(1, 1, 0, 1, 16'h0101, 2'd0, 1, 16'h0101, 3'd1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 16'h0202, 2'd1, 1, 16'h0101, 3'd2, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 16'hABCD, 2'd0, 0, 16'h0000, 3'd0, 0, 1));

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // ABCD must be absent from every tap, while holding and while shifting zeros
    for (int t = 0; t < 4; t++)
      step(mk(1, 0, 0, 0, 16'h0000, 2'(t), 0, 16'h0000, 3'd0, 0, 1), $sformatf("clr_tap%0d", t));
    for (int i = 0; i < 3; i++)
      step(mk(1, 1, 0, 0, 16'h0000, 2'd3, 0, 16'h0000, 3'd0, 0, 1), $sformatf("clr_shift%0d", i));

    // fill four valid samples: stages become C4,C3,C2,C1
    step(mk(1, 1, 0, 1, 16'h00C1, 2'd0, 1, 16'h00C1, 3'd1, 0, 0), "fillc1");
    step(mk(1, 1, 0, 1, 16'h00C2, 2'd0, 1, 16'h00C2, 3'd2, 0, 0), "fillc2");
    step(mk(1, 1, 0, 1, 16'h00C3, 2'd0, 1, 16'h00C3, 3'd3, 0, 0), "fillc3");
    step(mk(1, 1, 0, 1, 16'h00C4, 2'd0, 1, 16'h00C4, 3'd4, 1, 0), "fillc4");

    // tap sweep on the hold; combinational tap change, no state disturbance
    begin
      logic [15:0] exp4 [4];
      logic [15:0] exp3 [4];
      exp4[0] = 16'h00C4; exp4[1] = 16'h00C3; exp4[2] = 16'h00C2; exp4[3] = 16'h00C1;
      exp3[0] = 16'h00C4; exp3[1] = 16'h00C3; exp3[2] = 16'h00C2; exp3[3] = 16'h00C2;
      for (int t = 0; t < 4; t++) begin
        step(mk(1, 0, 0, 0, 16'h7777, 2'(t), 1, exp4[t], 3'd4, 1, 0), $sformatf("tap%0d", t));
        chk($sformatf("d3_tap%0d.data", t),  {16'b0, o3_data},  {16'b0, exp3[t]});
        chk($sformatf("d3_tap%0d.valid", t), {31'b0, o3_valid}, 32'd1);
        chk($sformatf("d3_tap%0d.full", t),  {31'b0, o3_full},  32'd1);
      end
    end

    // invalid 5A5A travelling down the chain
    step(mk(1, 1, 0, 0, 16'h5A5A, 2'd0, 0, 16'h5A5A, 3'd3, 0, 0), "gate_s0");
    step(mk(1, 1, 0, 1, 16'h0E01, 2'd1, 0, 16'h5A5A, 3'd3, 0, 0), "gate_s1");
    step(mk(1, 1, 0, 1, 16'h0E02, 2'd2, 0, 16'h5A5A, 3'd3, 0, 0), "gate_s2");
    step(mk(1, 1, 0, 1, 16'h0E03, 2'd3, 0, 16'h5A5A, 3'd3, 0, 0), "gate_s3");
    step(mk(1, 0, 0, 1, 16'hFFFF, 2'd0, 1, 16'h0E03, 3'd3, 0, 0), "gate_hold");
    // DEPTH=3 copy at clamped tap 3 -> stage 2 = 0E01 valid
    i_tap = 2'd3;
    #1;
    chk("d3_clamp.data",  {16'b0, o3_data},  32'h0E01);
    chk("d3_clamp.valid", {31'b0, o3_valid}, 32'd1);
    chk("d3_clamp.cnt",   {30'b0, o3_cnt},   32'd3);

    // mid-operation reset empties the chain
    step(mk(0, 1, 0, 1, 16'h4321, 2'd0, 0, 16'h0000, 3'd0, 0, 1), "midrst");
    step(mk(1, 1, 0, 1, 16'h4321, 2'd0, 1, 16'h4321, 3'd1, 0, 0), "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
